// File: rtl/music_beat_ctrl_if.sv
// Control and beat-output bundle between the button/front-panel side and the
// beat sequencer that feeds the tone tables.
interface music_beat_ctrl_if;
   logic        play_pause;
   logic        stop;
   logic        loop;
   logic [1:0]  tempo_sel;
   logic [11:0] ibeat_num;
   logic        en;
   logic        beat_tick;
   logic        done;
   logic        paused;

   modport master (
      output play_pause, stop, loop, tempo_sel,
      input  ibeat_num, en, beat_tick, done, paused
   );

   modport slave (
      input  play_pause, stop, loop, tempo_sel,
      output ibeat_num, en, beat_tick, done, paused
   );
endinterface

// File: rtl/music_beat_ctrl.sv
// Beat sequencer: play/pause/stop FSM with a tempo-selectable beat divider,
// producing the beat index and enable consumed by the tone lookup tables.
module music_beat_ctrl #(
   parameter int unsigned BASE_DIV = 25_000_000,
   parameter int unsigned BEAT_LEN = 64
) (
   input  logic             clk,
   input  logic             rst,
   music_beat_ctrl_if.slave bus
);

   localparam logic [31:0] DIV_NORM  = 32'(BASE_DIV);
   localparam logic [11:0] LAST_BEAT = 12'(BEAT_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Beat period for a tempo code; shifts only, so no multiplier is inferred.
   function automatic logic [31:0] tempo_period(input logic [1:0] sel);
      logic [31:0] per;
      case (sel)
         2'd0:    per = DIV_NORM;
         2'd1:    per = DIV_NORM >> 1;
         2'd2:    per = DIV_NORM << 1;
         2'd3:    per = DIV_NORM >> 2;
         default: per = DIV_NORM;
      endcase
      return per;
   endfunction

   state_t      state_r, state_s;
   logic [31:0] div_cnt_r, div_cnt_s;
   logic [31:0] div_per_r, div_per_s;
   logic [11:0] ibeat_r, ibeat_s;
   logic        en_r, en_s;
   logic        tick_r, tick_s;
   logic        done_r, done_s;
   logic        paused_r, paused_s;
   logic        boundary_s;

   assign boundary_s = (div_cnt_r == (div_per_r - 32'd1));

   // Next-state, divider and beat-index logic; stop beats play_pause beats advance.
   always_comb begin
      state_s   = state_r;
      div_cnt_s = div_cnt_r;
      div_per_s = div_per_r;
      ibeat_s   = ibeat_r;
      tick_s    = 1'b0;
      done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            div_cnt_s = 32'd0;
            ibeat_s   = 12'd0;
            if (bus.play_pause) begin
               state_s   = ST_PLAY;
               div_per_s = tempo_period(bus.tempo_sel);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PLAY: begin
            if (bus.stop) begin
               state_s   = ST_IDLE;
               div_cnt_s = 32'd0;
               ibeat_s   = 12'd0;
            end else if (bus.play_pause) begin
               // Count is held so a pause on the boundary replays the advance on resume.
               state_s = ST_PAUSE;
            end else if (boundary_s) begin
               div_cnt_s = 32'd0;
               div_per_s = tempo_period(bus.tempo_sel);
               if (ibeat_r < LAST_BEAT) begin
                  ibeat_s = ibeat_r + 12'd1;
                  tick_s  = 1'b1;
               end else if (bus.loop) begin
                  ibeat_s = 12'd0;
                  tick_s  = 1'b1;
               end else begin
                  state_s = ST_IDLE;
                  ibeat_s = 12'd0;
                  done_s  = 1'b1;
               end
            end else begin
               div_cnt_s = div_cnt_r + 32'd1;
            end
         end
         ST_PAUSE: begin
            if (bus.stop) begin
               state_s   = ST_IDLE;
               div_cnt_s = 32'd0;
               ibeat_s   = 12'd0;
            end else if (bus.play_pause) begin
               state_s = ST_PLAY;
            end else begin
               state_s = ST_PAUSE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            div_cnt_s = 32'd0;
            ibeat_s   = 12'd0;
         end
      endcase
      en_s     = (state_s == ST_PLAY);
      paused_s = (state_s == ST_PAUSE);
   end

   // State, divider and registered outputs; rst low clears immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         div_cnt_r <= 32'd0;
         div_per_r <= DIV_NORM;
         ibeat_r   <= 12'd0;
         en_r      <= 1'b0;
         tick_r    <= 1'b0;
         done_r    <= 1'b0;
         paused_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         div_cnt_r <= div_cnt_s;
         div_per_r <= div_per_s;
         ibeat_r   <= ibeat_s;
         en_r      <= en_s;
         tick_r    <= tick_s;
         done_r    <= done_s;
         paused_r  <= paused_s;
      end
   end

   assign bus.ibeat_num = ibeat_r;
   assign bus.en        = en_r;
   assign bus.beat_tick = tick_r;
   assign bus.done      = done_r;
   assign bus.paused    = paused_r;

   music_beat_ctrl_chk #(
      .LAST_BEAT (LAST_BEAT)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .ibeat_num (ibeat_r),
      .en        (en_r),
      .beat_tick (tick_r),
      .done      (done_r),
      .paused    (paused_r),
      .div_cnt   (div_cnt_r),
      .div_per   (div_per_r)
   );

endmodule

// Invariants of the beat sequencer outputs and divider.
module music_beat_ctrl_chk #(
   parameter logic [11:0] LAST_BEAT = 12'd63
) (
   input logic        clk,
   input logic        rst,
   input logic [11:0] ibeat_num,
   input logic        en,
   input logic        beat_tick,
   input logic        done,
   input logic        paused,
   input logic [31:0] div_cnt,
   input logic [31:0] div_per
);

   a_en_paused_excl : assert property (@(posedge clk) disable iff (!rst)
      !(en && paused));

   a_done_silent : assert property (@(posedge clk) disable iff (!rst)
      done |-> (!en && !beat_tick));

   a_beat_range : assert property (@(posedge clk) disable iff (!rst)
      ibeat_num <= LAST_BEAT);

   a_cnt_below_per : assert property (@(posedge clk) disable iff (!rst)
      div_cnt < div_per);

endmodule

// File: tb/tb_music_beat_ctrl.sv
// Directed bench for music_beat_ctrl with BASE_DIV=8, BEAT_LEN=4.
module tb_music_beat_ctrl;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   music_beat_ctrl_if bus ();

   music_beat_ctrl #(
      .BASE_DIV (8),
      .BEAT_LEN (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pp;
      logic        stp;
      logic        lp;
      logic [1:0]  tmp;
      int          n;
      logic [11:0] ibeat;
      logic        en;
      logic        tick;
      logic        done;
      logic        paused;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic pp, input logic stp, input logic lp, input logic [1:0] tmp,
                      input int n, input logic [11:0] ibeat, input logic en, input logic tick,
                      input logic done, input logic paused);
      vec_t v;
      v.pp = pp; v.stp = stp; v.lp = lp; v.tmp = tmp; v.n = n;
      v.ibeat = ibeat; v.en = en; v.tick = tick; v.done = done; v.paused = paused;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [11:0] ibeat, input logic en, input logic tick,
                          input logic done, input logic paused);
      chk("ibeat_num", idx, bus.ibeat_num, ibeat);
      chk("en", idx, 12'(bus.en), 12'(en));
      chk("beat_tick", idx, 12'(bus.beat_tick), 12'(tick));
      chk("done", idx, 12'(bus.done), 12'(done));
      chk("paused", idx, 12'(bus.paused), 12'(paused));
   endtask

   // Present pulses for one edge, then run n edges total; ends 1 ns after the last edge.
   task automatic apply(input logic pp, input logic stp, input int n);
      bus.play_pause = pp;
      bus.stop       = stp;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         bus.play_pause = 1'b0;
         bus.stop       = 1'b0;
      end
   endtask

   initial begin
      pass_cnt       = 0;
      total_cnt      = 0;
      rst            = 1'b0;
      bus.play_pause = 1'b0;
      bus.stop       = 1'b0;
      bus.loop       = 1'b0;
      bus.tempo_sel  = 2'd0;

      //   pp    stp   lp    tmp   n   ibeat  en    tick  done  paused
      // basic song
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 7,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 7,  12'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 8,  12'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 7,  12'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'd0, 2,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // looping, three passes, then stop+play_pause together
      add(1'b1, 1'b0, 1'b1, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 8,  12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 16, 12'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 8,  12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 31, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 32, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 2'd0, 8,  12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b1, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 2,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // tempo 0 -> 3 at div_cnt 2 of beat 0
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 2,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd3, 5,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd3, 1,  12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd3, 1,  12'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd3, 1,  12'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd3, 2,  12'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      // pause on a beat boundary, resume advances at once
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 7,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 2'd0, 3,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      // stop on the song-end boundary: no done
      add(1'b0, 1'b0, 1'b0, 2'd0, 23, 12'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // stop from pause
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, 2'd0, 1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all(1000, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      apply(1'b0, 1'b0, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         bus.loop      = tbl[i].lp;
         bus.tempo_sel = tbl[i].tmp;
         apply(tbl[i].pp, tbl[i].stp, tbl[i].n);
         chk_all(i, tbl[i].ibeat, tbl[i].en, tbl[i].tick, tbl[i].done, tbl[i].paused);
      end

      // pause at div_cnt 5 of beat 1, hold 20 cycles, resume
      bus.loop      = 1'b0;
      bus.tempo_sel = 2'd0;
      apply(1'b1, 1'b0, 1);
      apply(1'b0, 1'b0, 8);
      chk_all(2000, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 5);
      apply(1'b1, 1'b0, 1);
      chk_all(2001, 12'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int h = 0; h < 20; h++) begin
         apply(1'b0, 1'b0, 1);
         chk_all(2100 + h, 12'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      apply(1'b1, 1'b0, 1);
      chk_all(2002, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 2);
      chk_all(2003, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1);
      chk_all(2004, 12'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 1);

      // asynchronous reset mid-beat at beat 2
      apply(1'b1, 1'b0, 1);
      apply(1'b0, 1'b0, 16);
      chk_all(3000, 12'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 3);
      #3;
      rst = 1'b0;
      #1;
      chk_all(3001, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #4;
      rst = 1'b1;
      apply(1'b0, 1'b0, 5);
      chk_all(3002, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1);
      chk_all(3003, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 8);
      chk_all(3004, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
